// File: rtl/exp_lut_loader.sv
// Ping-pong RBF kernel LUT: a streamed table is written into the idle bank and
// swapped onto the read port in one cycle once all entries have arrived.
module exp_lut_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int KMAX       = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_abort,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  lut_valid,
  output logic                  active_bank,
  output logic                  busy,
  output logic                  mono_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic signed [DATA_WIDTH-1:0] KMAX_S = DATA_WIDTH'(KMAX);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [DATA_WIDTH-1:0] x);
    if (x[DATA_WIDTH-1])  return '0;
    else if (x > KMAX_S)  return KMAX_S;
    else                  return x;
  endfunction

  state_t                        state_q, state_d;
  logic [ADDR_WIDTH-1:0]         cnt_q, cnt_d;
  logic                          flag_q, flag_d;
  logic                          bank_q, bank_d;
  logic                          valid_q, valid_d;
  logic                          err_q, err_d;
  logic signed [DATA_WIDTH-1:0]  prev_q, prev_d;
  logic [DATA_WIDTH-1:0]         rd_data_q;
  logic                          wr_en;
  logic signed [DATA_WIDTH-1:0]  wr_sat;

  // Both banks live in one array; the MSB of the index selects the bank.
  logic [DATA_WIDTH-1:0] mem [2*DEPTH];

  assign wr_sat = sat(wr_data);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flag_d   = flag_q;
    prev_d   = prev_q;
    bank_d   = bank_q;
    valid_d  = valid_q;
    err_d    = err_q;
    wr_en    = 1'b0;
    wr_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          cnt_d   = '0;
          flag_d  = 1'b0;
        end
      end
      LOAD: begin
        wr_ready = 1'b1;
        if (load_abort) begin
          state_d = IDLE;
        end else if (wr_valid) begin
          wr_en  = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          prev_d = wr_sat;
          // Entry 0 has no predecessor, so it can never flag.
          if (cnt_q != '0 && wr_sat > prev_q) flag_d = 1'b1;
          if (cnt_q == '1) state_d = COMMIT;
        end
      end
      COMMIT: begin
        bank_d  = ~bank_q;
        valid_d = 1'b1;
        err_d   = flag_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      bank_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      bank_q  <= bank_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    prev_q <= prev_d;
    if (wr_en) mem[{~bank_q, cnt_q}] <= wr_sat;
  end

  // Read stage: uses the bank selected before any swap on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rd_data_q <= '0;
    else if (valid_q) rd_data_q <= mem[{bank_q, rd_addr}];
    else              rd_data_q <= '0;
  end

  assign rd_data     = rd_data_q;
  assign lut_valid   = valid_q;
  assign active_bank = bank_q;
  assign busy        = (state_q != IDLE);
  assign mono_err    = err_q;

endmodule

// File: tb/tb_exp_lut_loader.sv
// Directed-plus-random bench for exp_lut_loader with a table-level reference model.
module tb_exp_lut_loader;

  logic        clk = 1'b0;
  logic        rst, load_start, load_abort, wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic        lut_valid, active_bank, busy, mono_err;

  exp_lut_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_abort(load_abort),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .lut_valid(lut_valid),
    .active_bank(active_bank), .busy(busy), .mono_err(mono_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: the two banks as whole tables plus the visible status.
  int tbl [256];
  int mbank [2][256];
  int mact = 0;
  bit mvalid = 0;
  bit mmono = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int satf(input int x);
    if (x < 0) return 0;
    if (x > 256) return 256;
    return x;
  endfunction

  task automatic do_load(input bit rnd, input int abort_at, input bit mid);
    int idx, cyc;
    bit acc, aborted;
    int sv [256];
    bit mono;
    logic [31:0] old3;
    old3 = mvalid ? 32'(mbank[mact][3]) : 32'd0;
    rd_addr = 8'd3;
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    chk("busy_load", busy, 1);
    chk("ready_load", wr_ready, 1);
    idx = 0; cyc = 0; aborted = 0;
    while (idx < 256 && cyc < 3000) begin
      wr_data    = 16'(tbl[idx]);
      wr_valid   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      load_start = mid && (idx == 50);
      load_abort = (abort_at == idx);
      #1 acc = wr_valid && wr_ready && !load_abort;
      @(negedge clk); cyc++;
      load_start = 1'b0;
      if (load_abort) begin
        load_abort = 1'b0; aborted = 1; break;
      end
      if (acc) idx++;
      chk("rd_hold_old", rd_data, old3);
    end
    wr_valid = 1'b0;
    if (aborted) begin
      chk("abort_busy", busy, 0);
      chk("abort_bank", active_bank, 32'(mact));
      chk("abort_valid", lut_valid, 32'(mvalid));
      return;
    end
    chk("accept_count", idx, 256);
    chk("commit_ready", wr_ready, 0);
    chk("commit_busy", busy, 1);
    for (int n = 0; n < 256; n++) sv[n] = satf(tbl[n]);
    mono = 0;
    for (int n = 1; n < 256; n++) if (sv[n] > sv[n-1]) mono = 1;
    @(negedge clk);
    mact = 1 - mact;
    mbank[mact] = sv;
    mvalid = 1;
    mmono = mono;
    chk("post_busy", busy, 0);
    chk("post_bank", active_bank, 32'(mact));
    chk("post_valid", lut_valid, 1);
    chk("post_mono", mono_err, 32'(mmono));
    chk("rd_after_commit_old", rd_data, old3);
    @(negedge clk);
    chk("rd_new", rd_data, 32'(mbank[mact][3]));
    for (int a = 0; a < 256; a++) begin
      rd_addr = 8'(a);
      @(negedge clk);
      chk("table_read", rd_data, 32'(mbank[mact][a]));
    end
  endtask

  initial begin
    rst = 1'b1; load_start = 0; load_abort = 0; wr_valid = 0; wr_data = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", lut_valid, 0);
    chk("rst_bank", active_bank, 0);
    chk("rst_ready", wr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mono", mono_err, 0);
    for (int a = 0; a < 6; a++) begin
      rd_addr = 8'(a);
      @(negedge clk);
      chk("rst_rd", rd_data, 0);
    end

    // Table A: 256-i, plain stream.
    for (int i = 0; i < 256; i++) tbl[i] = 256 - i;
    do_load(0, -1, 0);
    rd_addr = 8'd10; @(negedge clk);
    chk("tableA_addr10", rd_data, 246);

    // Aborted load leaves table A live.
    for (int i = 0; i < 256; i++) tbl[i] = 5;
    do_load(0, 100, 0);
    rd_addr = 8'd10; @(negedge clk); @(negedge clk);
    chk("abort_addr10", rd_data, 246);

    // Table B: saturating entries, non-monotonic.
    tbl[0] = -5; tbl[1] = 300;
    for (int i = 2; i < 256; i++) tbl[i] = 256 - i;
    do_load(0, -1, 0);
    chk("B_mono", mono_err, 1);

    // Table C: monotonic 250-i, [3]=247.
    for (int i = 0; i < 256; i++) tbl[i] = 250 - i;
    do_load(1, -1, 0);
    chk("C_mono", mono_err, 0);

    // Table D: random, [3]=100, random valid gaps and a mid-load start.
    for (int i = 0; i < 256; i++) tbl[i] = int'($urandom_range(0, 500)) - 100;
    tbl[3] = 100;
    do_load(1, -1, 1);

    // Reset in the middle of a load.
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0; wr_valid = 1'b1; wr_data = 16'd7;
    repeat (5) @(negedge clk);
    rst = 1'b1; #1;
    chk("mid_rst_valid", lut_valid, 0);
    chk("mid_rst_bank", active_bank, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", wr_ready, 0);
    chk("mid_rst_mono", mono_err, 0);
    chk("mid_rst_rd", rd_data, 0);
    wr_valid = 1'b0;
    @(negedge clk); rst = 1'b0; rd_addr = 8'd3;
    @(negedge clk);
    chk("post_rst_rd", rd_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
